// File: rtl/clock_mode_controller.sv
// Time-of-day and alarm keeper with a five-state set-mode FSM driven by one-cycle button pulses.
// All outputs are registered; time advances on sec_tick except while hour or minute is being set.
module clock_mode_controller #(
   parameter int HOURS        = 24,
   parameter int MINUTES      = 60,
   parameter int RING_SECONDS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_tick,
   input  logic       btn_c,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic       btn_l,
   input  logic       btn_r,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [4:0] alm_hour,
   output logic [5:0] alm_min,
   output logic       alm_en,
   output logic [2:0] mode,
   output logic       ringing
);
   localparam int RW = $clog2(RING_SECONDS + 1);

   localparam logic [2:0] S_CLOCK    = 3'd0;
   localparam logic [2:0] S_SET_HR   = 3'd1;
   localparam logic [2:0] S_SET_MIN  = 3'd2;
   localparam logic [2:0] S_SET_AHR  = 3'd3;
   localparam logic [2:0] S_SET_AMIN = 3'd4;

   localparam logic [5:0]    HR_MAX    = 6'(HOURS - 1);
   localparam logic [5:0]    MN_MAX    = 6'(MINUTES - 1);
   localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECONDS);

   logic [4:0]    r_hour, r_alm_hour;
   logic [5:0]    r_minute, r_second, r_alm_min;
   logic          r_alm_en, r_ringing;
   logic [2:0]    r_mode;
   logic [RW-1:0] r_ring_cnt;

   logic       w_pc, w_pr, w_pl, w_pu, w_any;
   logic       w_advance, w_sec_wrap, w_min_wrap, w_trigger;
   logic [5:0] w_next_sec, w_next_min, w_min_inc, w_hr_inc6;
   logic [4:0] w_next_hr;
   logic [5:0] w_field_val, w_field_max, w_field_new;

   function automatic logic [5:0] f_step(input logic [5:0] v, input logic [5:0] max, input logic up);
      if (up) return (v == max) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0) ? max : v - 6'd1;
   endfunction

   // Only the highest-priority pending pulse acts: c > r > l > u > d.
   assign w_pc  = btn_c;
   assign w_pr  = btn_r & ~btn_c;
   assign w_pl  = btn_l & ~btn_c & ~btn_r;
   assign w_pu  = btn_u & ~btn_c & ~btn_r & ~btn_l;
   assign w_any = btn_c | btn_r | btn_l | btn_u | btn_d;

   assign w_advance  = sec_tick & (r_mode == S_CLOCK || r_mode == S_SET_AHR || r_mode == S_SET_AMIN);
   assign w_sec_wrap = (r_second == MN_MAX);
   assign w_min_wrap = (r_minute == MN_MAX);
   assign w_next_sec = f_step(r_second, MN_MAX, 1'b1);
   assign w_min_inc  = f_step(r_minute, MN_MAX, 1'b1);
   assign w_hr_inc6  = f_step({1'b0, r_hour}, HR_MAX, 1'b1);
   assign w_next_min = w_sec_wrap ? w_min_inc : r_minute;
   assign w_next_hr  = (w_sec_wrap && w_min_wrap) ? w_hr_inc6[4:0] : r_hour;

   // Alarm compares against the post-carry time at the instant the second wraps to 0.
   assign w_trigger = w_advance & w_sec_wrap & r_alm_en &
                      (w_next_hr == r_alm_hour) & (w_next_min == r_alm_min);

   always_comb begin
      w_field_val = 6'd0;
      w_field_max = MN_MAX;
      case (r_mode)
         S_SET_HR:   begin w_field_val = {1'b0, r_hour};     w_field_max = HR_MAX; end
         S_SET_MIN:  begin w_field_val = r_minute;           w_field_max = MN_MAX; end
         S_SET_AHR:  begin w_field_val = {1'b0, r_alm_hour}; w_field_max = HR_MAX; end
         S_SET_AMIN: begin w_field_val = r_alm_min;          w_field_max = MN_MAX; end
         default:    ;
      endcase
      w_field_new = f_step(w_field_val, w_field_max, w_pu);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hour     <= '0;
         r_minute   <= '0;
         r_second   <= '0;
         r_alm_hour <= '0;
         r_alm_min  <= '0;
         r_alm_en   <= 1'b0;
         r_mode     <= S_CLOCK;
         r_ringing  <= 1'b0;
         r_ring_cnt <= '0;
      end else begin
         if (w_advance) begin
            r_second <= w_next_sec;
            r_minute <= w_next_min;
            r_hour   <= w_next_hr;
         end

         if (r_ringing && w_any) begin
            r_ringing  <= 1'b0;
            r_ring_cnt <= '0;
         end else if (w_trigger) begin
            r_ringing  <= 1'b1;
            r_ring_cnt <= RING_LOAD;
         end else if (r_ringing && sec_tick) begin
            r_ring_cnt <= r_ring_cnt - 1'b1;
            r_ringing  <= (r_ring_cnt != RW'(1));
         end

         if (r_mode > S_SET_AMIN) r_mode <= S_CLOCK;

         // A pulse that silences the alarm is consumed and has no other effect.
         if (!r_ringing && w_any) begin
            case (r_mode)
               S_CLOCK: begin
                  if (w_pc)      r_mode   <= S_SET_HR;
                  else if (w_pu) r_alm_en <= ~r_alm_en;
               end
               S_SET_HR, S_SET_MIN, S_SET_AHR, S_SET_AMIN: begin
                  if (w_pc)      r_mode <= S_CLOCK;
                  else if (w_pr) r_mode <= (r_mode == S_SET_AMIN) ? S_SET_HR : r_mode + 3'd1;
                  else if (w_pl) r_mode <= (r_mode == S_SET_HR) ? S_SET_AMIN : r_mode - 3'd1;
                  else begin
                     case (r_mode)
                        S_SET_HR:  begin r_hour   <= w_field_new[4:0]; r_second <= '0; end
                        S_SET_MIN: begin r_minute <= w_field_new;      r_second <= '0; end
                        S_SET_AHR: r_alm_hour <= w_field_new[4:0];
                        default:   r_alm_min  <= w_field_new;
                     endcase
                  end
               end
               default: r_mode <= S_CLOCK;
            endcase
         end
      end
   end

   assign hour     = r_hour;
   assign minute   = r_minute;
   assign second   = r_second;
   assign alm_hour = r_alm_hour;
   assign alm_min  = r_alm_min;
   assign alm_en   = r_alm_en;
   assign mode     = r_mode;
   assign ringing  = r_ringing;
endmodule
